int_div_32: RTL
===============

// Module: int_div_32
// PURPOSE
//  Iterative radix-2 restoring integer divider; the inverse datapath of the pipelined multiplier.
//  Executes RISC-V M-extension DIV/DIVU/REM/REMU: one start pulse in, quotient+remainder out with a result_rdy pulse.
//  Sits in the execute stage beside the multiplier and shares its start/signed/result_rdy handshake style.
//  Not pipelined: one division in flight; busy back-pressures the issue logic.
// PARAMETERS
//  OPERAND_SIZE  32  operand/result width N (>=4); iteration count equals N
// PORTS
//  clk           in   1  clock; all registers update on the falling edge
//  rst_n         in   1  asynchronous active-low reset
//  start         in   1  request; sampled only in IDLE or DONE
//  signed_div_i  in   1  1 = two's-complement (DIV/REM), 0 = unsigned (DIVU/REMU)
//  X             in   N  dividend, sampled with start
//  Y             in   N  divisor, sampled with start
//  busy          out  1  high in DIV and FIX states
//  result_rdy    out  1  one-cycle pulse: Quotient/Remainder valid
//  Quotient      out  N  quotient, truncated toward zero
//  Remainder     out  N  remainder, sign follows dividend
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy, result_rdy, Quotient, Remainder, counter, work regs all 0.
//  States: IDLE, DIV, FIX, DONE. Transitions on falling clk edge k:
//  - IDLE/DONE, start=0: -> IDLE.
//  - IDLE/DONE, start=1, Y==0: -> DONE; Quotient=all ones, Remainder=X (both modes).
//  - IDLE/DONE, start=1, signed, X==1<<(N-1), Y==all ones: -> DONE; Quotient=X, Remainder=0.
//  - IDLE/DONE, start=1, otherwise: latch |X|,|Y| (raw if unsigned), neg_q=sX^sY, neg_r=sX
//    (signs only when signed_div_i=1); rem=0, quo=|X|, counter=N-1; -> DIV.
//  - DIV, each edge: {rem,quo}<<=1; if rem_shifted>=|Y| (N+1-bit compare) rem-=|Y|, quo[0]=1;
//    counter-=1; after counter 0 iteration -> FIX (exactly N iterations).
//  - FIX: Quotient = neg_q ? -quo : quo; Remainder = neg_r ? -rem : rem; -> DONE.
//  - DONE: result_rdy=1 for exactly this cycle; Quotient/Remainder hold until the next DONE.
//  Latency (start edge k -> result_rdy high): normal N+1 cycles (33 @ N=32); special cases 1 cycle.
//  Back-to-back: start in the DONE cycle is accepted; no idle bubble required.
//  start while busy=1: ignored, no queueing, inputs not sampled.
//  X,Y,signed_div_i may change freely after the start edge; only latched copies are used.
//  Reset mid-operation: aborts immediately; no result_rdy is ever produced for the aborted op.
//  Invariant: result_rdy and busy never high together; result_rdy never high two cycles running
//  unless a special-case start is accepted in DONE.
//  |X| of 1<<(N-1) handled as unsigned magnitude 2^(N-1); no extra width beyond N+1-bit remainder path.
//  Quotient*Y + Remainder == X (mod 2^N) for every Y!=0; |Remainder| < |Y|.
// TESTING
//  1. DIVU X=100,Y=7 -> after 33 cycles result_rdy=1, Quotient=14, Remainder=2; busy high 32+1 cycles.
//  2. DIV X=-7 (0xFFFFFFF9),Y=2 -> Quotient=0xFFFFFFFD (-3), Remainder=0xFFFFFFFF (-1); also X=7,Y=-2 -> Q=-3,R=1.
//  3. Y=0, X=5 (both modes) -> result_rdy 1 cycle after start, Quotient=0xFFFFFFFF, Remainder=5, busy never high.
//  4. DIV X=0x80000000,Y=0xFFFFFFFF -> 1 cycle, Quotient=0x80000000, Remainder=0; same in DIVU -> Q=0, R=0x80000000 after 33.
//  5. DIVU 0xFFFFFFFF/1 then start in DONE cycle with 0xFFFFFFFF/0xFFFFFFFF -> Q=0xFFFFFFFF,R=0 then Q=1,R=0, no bubble;
//     start pulses while busy produce no extra result_rdy.
//  6. Start 1000/3, assert rst_n=0 asynchronously at cycle 10 -> busy,result_rdy,Quotient,Remainder=0 at once;
//     after release, start 9/3 -> Q=3,R=0 in 33 cycles. Plus 10k random signed/unsigned vs reference model.

Source files
------------

// File: rtl/int_div_32.sv
// int_div_32: iterative radix-2 restoring divider (DIV/DIVU/REM/REMU).
// Ports: start/signed_div_i/X/Y in; busy/result_rdy/Quotient/Remainder out.
module int_div_32 #(
  parameter int OPERAND_SIZE = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    signed_div_i,
  input  logic [OPERAND_SIZE-1:0] X,
  input  logic [OPERAND_SIZE-1:0] Y,
  output logic                    busy,
  output logic                    result_rdy,
  output logic [OPERAND_SIZE-1:0] Quotient,
  output logic [OPERAND_SIZE-1:0] Remainder
);

  localparam int N  = OPERAND_SIZE;
  localparam int CW = $clog2(N);
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic [N-1:0]  qo_q, qo_d;
  logic [N-1:0]  ro_q, ro_d;
  logic          negq_q, negq_d;
  logic          negr_q, negr_d;

  logic          sx, sy;
  logic [N-1:0]  x_mag, y_mag;
  logic [N:0]    shl, sub;
  logic          fits;

  assign sx    = signed_div_i & X[N-1];
  assign sy    = signed_div_i & Y[N-1];
  // MIN_NEG negates to itself, which is its correct unsigned magnitude
  assign x_mag = sx ? -X : X;
  assign y_mag = sy ? -Y : Y;

  // rem < divisor always holds, so a borrow shows up in bit N
  assign shl  = {rem_q, quo_q[N-1]};
  assign sub  = shl - {1'b0, dvs_q};
  assign fits = ~sub[N];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qo_d    = qo_q;
    ro_d    = ro_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          if (Y == '0) begin
            qo_d    = '1;
            ro_d    = X;
            state_d = S_DONE;
          end else if (signed_div_i && X == MIN_NEG
                       && Y == '1) begin
            qo_d    = X;
            ro_d    = '0;
            state_d = S_DONE;
          end else begin
            rem_d   = '0;
            quo_d   = x_mag;
            dvs_d   = y_mag;
            negq_d  = sx ^ sy;
            negr_d  = sx;
            cnt_d   = CW'(N - 1);
            state_d = S_DIV;
          end
        end
      end
      S_DIV: begin
        rem_d = fits ? sub[N-1:0] : shl[N-1:0];
        quo_d = {quo_q[N-2:0], fits};
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FIX: begin
        qo_d    = negq_q ? -quo_q : quo_q;
        ro_d    = negr_q ? -rem_q : rem_q;
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // registers update on the falling clock edge
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qo_q    <= '0;
      ro_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qo_q    <= qo_d;
      ro_q    <= ro_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign busy       = (state_q == S_DIV) || (state_q == S_FIX);
  assign result_rdy = (state_q == S_DONE);
  assign Quotient   = qo_q;
  assign Remainder  = ro_q;

endmodule
